ddr4_mrs_cmd_gen: RTL and testbench

- Bench-side MRS command generator for the DDR4 RDIMM wrapper. It is the transmit end of the MRS decode used by the data-buffer delay-direction detector.
- Accepts a mode-register write request (MR number, 18-bit value, rank) over a valid/ready handshake. Drives the side-A and then the side-B copy of the MRS onto the DRAM-side CA bus, with address mirroring and side-B inversion applied.
- Enforces tMRD/tMOD spacing and tracks write-leveling state (MR1 A7) so benches can cross-check db_dly_dir.

---
 rtl/ddr4_mrs_pkg.sv | 57 +++++
 rtl/ddr4_mrs_encode.sv | 32 +++
 rtl/ddr4_mrs_cmd_gen.sv | 175 +++++++++++++++++
 tb/tb_ddr4_mrs_cmd_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ddr4_mrs_pkg.sv
// Shared types and CA-bus helpers for the DDR4 MRS command generator.
// Covers the mirroring and side-B inversion rules plus the odd-rank test.
package ddr4_mrs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD_A,
        ST_GAP_A,
        ST_CMD_B,
        ST_GAP_B
    } mrs_state_t;

    typedef struct packed {
        logic [17:0] a;
        logic [1:0]  ba;
        logic [1:0]  bg;
    } ca_t;

    localparam logic [17:0] SIDEB_INV_MASK = 18'h22BF8;
    // Deselect/NOP address: RAS_n/CAS_n/WE_n (A16:A14) high, everything else low.
    localparam logic [17:0] NOP_A = 18'h1C000;

    function automatic ca_t mirror_ca(input logic [17:0] a, input logic [1:0] ba,
                                      input logic [1:0] bg);
        ca_t r;
        r.a     = a;
        r.a[3]  = a[4];
        r.a[4]  = a[3];
        r.a[5]  = a[6];
        r.a[6]  = a[5];
        r.a[7]  = a[8];
        r.a[8]  = a[7];
        r.a[11] = a[13];
        r.a[13] = a[11];
        r.ba    = {ba[0], ba[1]};
        r.bg    = {bg[0], bg[1]};
        return r;
    endfunction

    function automatic ca_t invert_sideb(input logic [17:0] a, input logic [1:0] ba,
                                         input logic [1:0] bg);
        ca_t r;
        r.a  = a ^ SIDEB_INV_MASK;
        r.ba = ~ba;
        r.bg = ~bg;
        return r;
    endfunction

    function automatic logic rank_is_odd(input int rank, input int cs_num, input int slots);
        if (cs_num > 2)
            return (rank == 1) || (rank == 3);
        else if ((cs_num == 2) && (slots == 1))
            return rank == 1;
        return 1'b0;
    endfunction

endpackage

// File: rtl/ddr4_mrs_encode.sv
// Combinational MRS encoder: maps MR number, value, mirroring and side to the
// A/BA/BG bus value. Usable by any bench driver that needs the same encoding.
module ddr4_mrs_encode (
    input  logic [2:0]  mr,
    input  logic [17:0] data,
    input  logic        mirror,
    input  logic        side_b,
    output logic [17:0] a,
    output logic [1:0]  ba,
    output logic [1:0]  bg
);
    import ddr4_mrs_pkg::*;

    ca_t base;
    ca_t mir;
    ca_t fin;

    always_comb begin
        base.a        = data;
        base.a[16:14] = 3'b000;
        base.ba       = mr[1:0];
        base.bg       = {1'b0, mr[2]};
        mir           = mirror ? mirror_ca(base.a, base.ba, base.bg) : base;
        // Side B is derived from the bus value after mirroring.
        fin           = side_b ? invert_sideb(mir.a, mir.ba, mir.bg) : mir;
    end

    assign a  = fin.a;
    assign ba = fin.ba;
    assign bg = fin.bg;

endmodule

// File: rtl/ddr4_mrs_cmd_gen.sv
// Bench-side DDR4 MRS generator: side-A then side-B MRS per request, with
// tMRD/tMOD spacing and write-leveling (MR1 A7) tracking.
module ddr4_mrs_cmd_gen #(
    parameter string CA_MIRROR   = "OFF",
    parameter int    CS_NUM      = 2,
    parameter int    RDIMM_SLOTS = 1,
    parameter int    MC_ABITS    = 18,
    parameter int    INV_EN      = 1,
    parameter int    TMRD        = 8,
    parameter int    TMOD        = 24,
    localparam int   RW          = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic                ddr_ck,
    input  logic                ddr_reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_mr,
    input  logic [17:0]         req_data,
    input  logic [RW-1:0]       req_rank,
    output logic [CS_NUM-1:0]   ddr_cs_n,
    output logic                ddr_act_n,
    output logic [MC_ABITS-1:0] ddr_a,
    output logic [1:0]          ddr_ba,
    output logic [1:0]          ddr_bg,
    output logic                mrs_done,
    output logic                rank_err,
    output logic                wl_active,
    output logic [2:0]          dbg_state
);
    import ddr4_mrs_pkg::*;

    localparam int CW = ((TMOD > TMRD) ? $clog2(TMOD) : $clog2(TMRD)) + 1;

    // Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1.
    mrs_state_t     state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [2:0]     lat_mr, cur_mr;
    logic [17:0]    lat_data, cur_data;
    logic [RW-1:0]  lat_rank, cur_rank;
    logic           rank_ok, mirror, side_b;
    logic [17:0]    enc_a;
    logic [1:0]     enc_ba, enc_bg;

    logic [CS_NUM-1:0]   cs_n_d;
    logic [MC_ABITS-1:0] a_d;
    logic [1:0]          ba_d, bg_d;
    logic                ready_d, done_d, rerr_d, wl_d;

    // In IDLE the encoder looks at the live inputs so CMD_A can be registered on the handshake edge.
    assign cur_mr   = (state == ST_IDLE) ? req_mr   : lat_mr;
    assign cur_data = (state == ST_IDLE) ? req_data : lat_data;
    assign cur_rank = (state == ST_IDLE) ? req_rank : lat_rank;
    assign rank_ok  = int'(cur_rank) < CS_NUM;
    assign mirror   = (CA_MIRROR == "ON") && rank_is_odd(int'(cur_rank), CS_NUM, RDIMM_SLOTS);
    assign side_b   = (state_next == ST_CMD_B);
    assign dbg_state = state;

    ddr4_mrs_encode u_encode (
        .mr     (cur_mr),
        .data   (cur_data),
        .mirror (mirror),
        .side_b (side_b),
        .a      (enc_a),
        .ba     (enc_ba),
        .bg     (enc_bg)
    );

    always_ff @(posedge ddr_ck or negedge ddr_reset_n) begin
        if (!ddr_reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    state_next = ST_CMD_A;
                    cnt_next   = '0;
                end
            end
            ST_CMD_A: begin
                // Without side B the tMOD wait starts straight after CMD_A.
                if (INV_EN != 0) begin
                    state_next = ST_GAP_A;
                    cnt_next   = CW'(TMRD - 2);
                end else begin
                    state_next = ST_GAP_B;
                    cnt_next   = CW'(TMOD - 2);
                end
            end
            ST_GAP_A: begin
                if (cnt == '0) begin
                    state_next = (INV_EN != 0) ? ST_CMD_B : ST_GAP_B;
                    cnt_next   = (INV_EN != 0) ? '0 : CW'(TMOD - 2);
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_CMD_B: begin
                state_next = ST_GAP_B;
                cnt_next   = CW'(TMOD - 2);
            end
            ST_GAP_B: begin
                if (cnt == '0) state_next = ST_IDLE;
                else           cnt_next   = cnt - CW'(1);
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered, so their next values are decoded from the next state.
    always_comb begin
        cs_n_d      = '1;
        a_d         = '0;
        a_d[17:0]   = NOP_A;
        ba_d        = 2'b00;
        bg_d        = 2'b00;
        ready_d     = (state_next == ST_IDLE);
        done_d      = (state_next == ST_GAP_B) && (cnt_next == '0);
        rerr_d      = (state_next == ST_CMD_A) && !rank_ok;
        wl_d        = wl_active;
        if ((state_next == ST_CMD_A) || (state_next == ST_CMD_B)) begin
            for (int i = 0; i < CS_NUM; i++)
                cs_n_d[i] = !(rank_ok && (int'(cur_rank) == i));
            a_d[17:0] = enc_a;
            ba_d      = enc_ba;
            bg_d      = enc_bg;
        end
        if ((state_next == ST_CMD_A) && rank_ok && (cur_mr == 3'd1))
            wl_d = cur_data[7];
    end

    always_ff @(posedge ddr_ck or negedge ddr_reset_n) begin
        if (!ddr_reset_n) begin
            lat_mr    <= '0;
            lat_data  <= '0;
            lat_rank  <= '0;
            ddr_cs_n  <= '1;
            ddr_act_n <= 1'b1;
            ddr_a     <= {{(MC_ABITS-18){1'b0}}, NOP_A} ;
            ddr_ba    <= 2'b00;
            ddr_bg    <= 2'b00;
            req_ready <= 1'b0;
            mrs_done  <= 1'b0;
            rank_err  <= 1'b0;
            wl_active <= 1'b0;
        end else begin
            if (state == ST_IDLE && req_valid && req_ready) begin
                lat_mr   <= req_mr;
                lat_data <= req_data;
                lat_rank <= req_rank;
            end
            ddr_cs_n  <= cs_n_d;
            ddr_act_n <= 1'b1;
            ddr_a     <= a_d;
            ddr_ba    <= ba_d;
            ddr_bg    <= bg_d;
            req_ready <= ready_d;
            mrs_done  <= done_d;
            rank_err  <= rerr_d;
            wl_active <= wl_d;
        end
    end

endmodule

// File: tb/tb_ddr4_mrs_cmd_gen.sv
// Bench for ddr4_mrs_cmd_gen: two instances (mirrored 2-rank with side B, and
// 1-CS side-A-only) against a cycle-offset reference model.
module tb_ddr4_mrs_cmd_gen;

    localparam logic [31:0] RESET_WORD = {3'b000, 4'b0000, 2'b11, 1'b1, 18'h1C000, 2'b00, 2'b00};
    localparam logic [31:0] CMD_MASK   = 32'hFFC0_0000;

    logic        ck = 1'b0;
    logic        rst_n;
    logic [1:0]  vld;
    logic [2:0]  mr;
    logic [17:0] dat;
    logic        rank;

    logic        rdy0, done0, rerr0, wl0, act0;
    logic [1:0]  cs0, ba0, bg0;
    logic [17:0] a0;
    logic [2:0]  dbg0;
    logic        rdy1, done1, rerr1, wl1, act1;
    logic [0:0]  cs1;
    logic [1:0]  ba1, bg1;
    logic [17:0] a1;
    logic [2:0]  dbg1;

    int total = 0;
    int bad   = 0;

    int m_tmrd[2] = '{8, 4};
    int m_tmod[2] = '{24, 6};
    int m_cs[2]   = '{2, 1};
    bit m_mir[2]  = '{1'b1, 1'b0};
    bit m_inv[2]  = '{1'b1, 1'b0};
    bit m_wl[2]   = '{1'b0, 1'b0};
    logic [31:0] cap_a, cap_b;

    always #5 ck = ~ck;

    ddr4_mrs_cmd_gen #(.CA_MIRROR("ON"), .CS_NUM(2), .INV_EN(1), .TMRD(8), .TMOD(24)) u0 (
        .ddr_ck(ck), .ddr_reset_n(rst_n), .req_valid(vld[0]), .req_ready(rdy0),
        .req_mr(mr), .req_data(dat), .req_rank(rank), .ddr_cs_n(cs0), .ddr_act_n(act0),
        .ddr_a(a0), .ddr_ba(ba0), .ddr_bg(bg0), .mrs_done(done0), .rank_err(rerr0),
        .wl_active(wl0), .dbg_state(dbg0)
    );

    ddr4_mrs_cmd_gen #(.CA_MIRROR("OFF"), .CS_NUM(1), .INV_EN(0), .TMRD(4), .TMOD(6)) u1 (
        .ddr_ck(ck), .ddr_reset_n(rst_n), .req_valid(vld[1]), .req_ready(rdy1),
        .req_mr(mr), .req_data(dat), .req_rank(rank), .ddr_cs_n(cs1), .ddr_act_n(act1),
        .ddr_a(a1), .ddr_ba(ba1), .ddr_bg(bg1), .mrs_done(done1), .rank_err(rerr1),
        .wl_active(wl1), .dbg_state(dbg1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // {ready, done, rank_err, wl, cs_n[1:0], act_n, a, ba, bg}; instance 1 pads cs_n[1] with 1.
    function automatic logic [31:0] obs(input int d);
        if (d == 0) return {3'b000, rdy0, done0, rerr0, wl0, cs0, act0, a0, ba0, bg0};
        return {3'b000, rdy1, done1, rerr1, wl1, 1'b1, cs1, act1, a1, ba1, bg1};
    endfunction

    function automatic bit model_odd(input int cs, input int r);
        if (cs > 2) return (r == 1) || (r == 3);
        if (cs == 2) return r == 1;
        return 1'b0;
    endfunction

    function automatic void model_cmd(input bit sb, input logic [2:0] m, input logic [17:0] v,
                                      input bit mir, output logic [17:0] a,
                                      output logic [1:0] ba, output logic [1:0] bg);
        int   pa[4] = '{3, 5, 7, 11};
        int   pb[4] = '{4, 6, 8, 13};
        logic t;
        a = v;
        a[16:14] = 3'b000;
        ba = m[1:0];
        bg = {1'b0, m[2]};
        if (mir) begin
            for (int i = 0; i < 4; i++) begin
                t = a[pa[i]]; a[pa[i]] = a[pb[i]]; a[pb[i]] = t;
            end
            ba = {ba[0], ba[1]};
            bg = {bg[0], bg[1]};
        end
        if (sb) begin
            a  = a ^ 18'h22BF8;
            ba = ~ba;
            bg = ~bg;
        end
    endfunction

    // Called at a negedge with the instance idle; returns at the negedge where req_ready is back.
    task automatic run_req(input int d, input logic [2:0] r_mr, input logic [17:0] r_data,
                           input logic r_rank);
        int          cmdb, last, kend;
        bit          valid, mir;
        logic [17:0] ea;
        logic [1:0]  eba, ebg, ecs;
        logic [31:0] e, m, g;
        check_val($sformatf("pre_ready_d%0d", d), {31'b0, obs(d) >> 28 & 32'd1} , 32'd1);
        valid = int'(r_rank) < m_cs[d];
        mir   = m_mir[d] && model_odd(m_cs[d], int'(r_rank));
        cmdb  = m_inv[d] ? 1 + m_tmrd[d] : -1;
        last  = m_inv[d] ? cmdb : 1;
        kend  = last + m_tmod[d];
        mr = r_mr; dat = r_data; rank = r_rank; vld[d] = 1'b1;
        @(posedge ck);
        for (int k = 1; k <= kend; k++) begin
            @(negedge ck);
            if (k == 1 && valid && r_mr == 3'd1) m_wl[d] = r_data[7];
            ecs = 2'b11; ea = 18'h1C000; eba = 2'b00; ebg = 2'b00; m = '1;
            if (k == 1 || k == cmdb) begin
                model_cmd(k == cmdb, r_mr, r_data, mir, ea, eba, ebg);
                if (valid) ecs[r_rank] = 1'b0;
                else       m = CMD_MASK;
            end
            e = {3'b000, k == kend, k == kend - 1, (k == 1) && !valid, m_wl[d], ecs, 1'b1, ea, eba, ebg};
            g = obs(d);
            check_val($sformatf("d%0d_mr%0d_k%0d", d, r_mr, k), g & m, e & m);
            if (k == 1)    cap_a = g;
            if (k == cmdb) cap_b = g;
            if (k < kend) begin
                vld[d] = 1'($urandom_range(0, 1));
                mr = 3'($urandom); dat = 18'($urandom); rank = 1'($urandom);
            end else begin
                vld = 2'b00;
            end
        end
    endtask

    task automatic reset_mid();
        mr = 3'd1; dat = 18'h00080; rank = 1'b0; vld[0] = 1'b1;
        @(posedge ck);
        @(negedge ck);
        vld[0] = 1'b0;
        check_val("rstmid_wl_set", {31'b0, wl0}, 32'd1);
        repeat (2) @(negedge ck);
        #2 rst_n = 1'b0;
        #1;
        check_val("rstmid_async_d0", obs(0), RESET_WORD);
        check_val("rstmid_async_d1", obs(1), RESET_WORD);
        for (int i = 0; i < 12; i++) begin
            @(negedge ck);
            check_val($sformatf("rstmid_hold_%0d", i), obs(0), RESET_WORD);
        end
        m_wl[0] = 1'b0;
        m_wl[1] = 1'b0;
        rst_n = 1'b1;
        @(negedge ck);
        check_val("rstmid_ready_back", {31'b0, rdy0}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; vld = 2'b00; mr = '0; dat = '0; rank = 1'b0;
        repeat (3) @(negedge ck);
        check_val("reset_d0", obs(0), RESET_WORD);
        check_val("reset_d1", obs(1), RESET_WORD);
        rst_n = 1'b1;
        @(negedge ck);

        run_req(0, 3'd1, 18'h00080, 1'b0);
        check_val("kat_nomir_a", cap_a & 32'h01FF_FFFF, {7'b0, 2'b10, 1'b1, 18'h00080, 2'b01, 2'b00});
        check_val("kat_nomir_b", cap_b & 32'h01FF_FFFF, {7'b0, 2'b10, 1'b1, 18'h22B78, 2'b10, 2'b11});
        check_val("kat_wl_on", {31'b0, wl0}, 32'd1);

        run_req(0, 3'd1, 18'h00080, 1'b1);
        check_val("kat_mir_a", cap_a & 32'h01FF_FFFF, {7'b0, 2'b01, 1'b1, 18'h00100, 2'b10, 2'b00});
        check_val("kat_mir_b", cap_b & 32'h01FF_FFFF, {7'b0, 2'b01, 1'b1, 18'h22AF8, 2'b01, 2'b11});

        run_req(0, 3'd1, 18'h00000, 1'b0);
        check_val("kat_wl_off", {31'b0, wl0}, 32'd0);
        run_req(0, 3'd1, 18'h00080, 1'b0);
        run_req(0, 3'd2, 18'h00080, 1'b0);
        check_val("kat_wl_mr2_keep", {31'b0, wl0}, 32'd1);

        run_req(1, 3'd3, 18'h00004, 1'b0);
        check_val("kat_sidea_only", cap_a & 32'h01FF_FFFF, {7'b0, 2'b10, 1'b1, 18'h00004, 2'b11, 2'b00});
        run_req(1, 3'd1, 18'h00080, 1'b1);
        check_val("kat_badrank_wl", {31'b0, wl1}, 32'd0);

        reset_mid();
        run_req(0, 3'd1, 18'h00080, 1'b0);

        for (int n = 0; n < 40; n++)
            run_req($urandom_range(0, 1), 3'($urandom), 18'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
